// File: rtl/rr_priority_arbiter_pkg.sv
// Shared constants and state type for the clocked round-robin / fixed-priority arbiter.
package rr_priority_arbiter_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_priority_arbiter_if #(
  parameter int N = 8
) ();
  import rr_priority_arbiter_pkg::*;

  logic [N-1:0]         req;
  logic                 mode;
  logic [N-1:0]         gnt;
  logic                 gnt_valid;
  logic [$clog2(N)-1:0] gnt_id;

  modport master (
    output req,
    output mode,
    input  gnt,
    input  gnt_valid,
    input  gnt_id
  );

  modport slave (
    input  req,
    input  mode,
    output gnt,
    output gnt_valid,
    output gnt_id
  );

endinterface

// File: rtl/rr_priority_arbiter_pick.sv
// Combinational winner search: first set bit of cand at or after start, wrapping N-1 -> 0.
module rr_pick
  import rr_priority_arbiter_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl_s;
  logic [2*N-1:0] masked_s;
  logic           hit_s;

  assign dbl_s = {cand, cand};

  // Drop bits below start in the doubled vector; the upper copy supplies the wrap-around.
  always_comb begin
    masked_s = '0;
    for (int i = 0; i < 2*N; i++) begin
      masked_s[i] = dbl_s[i] & (i >= int'(start));
    end
  end

  // Lowest surviving bit wins; its position folds back into 0..N-1.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    hit_s = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      hit_s = !found && masked_s[i];
      idx   = hit_s ? IW'(i % N) : idx;
      found = found | masked_s[i];
    end
  end

  assign onehot = found ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/rr_priority_arbiter.sv
// Clocked N-way arbiter: registered one-hot grant, fixed or round-robin selection,
// grant lock while the owner requests, and an optional bounded hold time.
module rr_priority_arbiter
  import rr_priority_arbiter_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  parameter int IW       = $clog2(N),
  parameter int CW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input logic                  clk,
  input logic                  rst,
  rr_priority_arbiter_if.slave bus
);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

  state_t        state_r;
  logic [IW-1:0] owner_r;
  logic [IW-1:0] ptr_r;
  logic [CW-1:0] cnt_r;
  logic [N-1:0]  gnt_r;
  logic          gnt_valid_r;

  logic [N-1:0]  owner_oh_s;
  logic          owner_req_s;
  logic          expired_s;
  logic          hold_s;
  logic          regrant_s;
  logic [N-1:0]  cand_s;
  logic [IW-1:0] start_s;
  logic          win_found_s;
  logic [N-1:0]  win_oh_s;
  logic [IW-1:0] win_idx_s;

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] w);
    if (int'(w) == N - 1) begin
      return '0;
    end else begin
      return w + IW'(1'b1);
    end
  endfunction

  assign owner_oh_s  = {{(N-1){1'b0}}, 1'b1} << owner_r;
  assign owner_req_s = (state_r == GRANT) && bus.req[owner_r];

  // Arbitration inputs: on expiry the current owner is excluded so others get a turn.
  always_comb begin
    if (MAX_HOLD != 0) begin
      expired_s = (cnt_r >= HOLD_LIM);
    end else begin
      expired_s = 1'b0;
    end
    hold_s    = owner_req_s && !expired_s;
    regrant_s = owner_req_s && expired_s;
    if (regrant_s) begin
      cand_s = bus.req & ~owner_oh_s;
    end else begin
      cand_s = bus.req;
    end
    start_s = (bus.mode == MODE_RR) ? ptr_r : '0;
  end

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .cand   (cand_s),
    .start  (start_s),
    .found  (win_found_s),
    .onehot (win_oh_s),
    .idx    (win_idx_s)
  );

  // FSM, hold counter, RR pointer and registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= '0;
      ptr_r       <= '0;
      cnt_r       <= '0;
      gnt_r       <= '0;
      gnt_valid_r <= 1'b0;
    end else if (hold_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else if (win_found_s) begin
      state_r     <= GRANT;
      owner_r     <= win_idx_s;
      gnt_r       <= win_oh_s;
      gnt_valid_r <= 1'b1;
      cnt_r       <= CNT_ONE;
      if (bus.mode == MODE_RR) begin
        ptr_r <= ptr_after(win_idx_s);
      end else begin
        ptr_r <= ptr_r;
      end
    end else if (regrant_s) begin
      // Nobody else wants the resource: owner keeps it with a fresh hold window.
      cnt_r <= CNT_ONE;
      if (bus.mode == MODE_RR) begin
        ptr_r <= ptr_after(owner_r);
      end else begin
        ptr_r <= ptr_r;
      end
    end else begin
      state_r     <= IDLE;
      owner_r     <= '0;
      cnt_r       <= '0;
      gnt_r       <= '0;
      gnt_valid_r <= 1'b0;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.gnt_id    = owner_r;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench: one unlimited-hold fixed-priority instance and one MAX_HOLD=4 instance.
module tb_rr_priority_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rr_priority_arbiter_if #(.N(8)) a0 ();
  rr_priority_arbiter_if #(.N(8)) a4 ();

  rr_priority_arbiter #(.N(8), .MAX_HOLD(0)) dut0 (.clk(clk), .rst(rst), .bus(a0));
  rr_priority_arbiter #(.N(8), .MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(a4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] oh_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Checks grant, valid and id together against an expected one-hot (or zero) grant.
  task automatic chk_bus(input string tag, input logic [7:0] g, input logic v,
                         input logic [2:0] id, input logic [7:0] eg);
    chk({tag, "_gnt"}, {24'd0, g}, {24'd0, eg});
    chk({tag, "_valid"}, {31'd0, v}, {31'd0, |eg});
    chk({tag, "_id"}, {29'd0, id}, {29'd0, oh_idx(eg)});
  endtask

  initial begin
    logic [7:0] e;
    rst     = 1'b1;
    a0.req  = 8'hFF;
    a0.mode = 1'b0;
    a4.req  = 8'hFF;
    a4.mode = 1'b1;

    for (int c = 0; c < 3; c++) begin
      tick();
      chk_bus("rst_a4", a4.gnt, a4.gnt_valid, a4.gnt_id, 8'h00);
      chk_bus("rst_a0", a0.gnt, a0.gnt_valid, a0.gnt_id, 8'h00);
    end
    rst = 1'b0;
    tick();
    chk_bus("first_rr", a4.gnt, a4.gnt_valid, a4.gnt_id, 8'h01);

    // RR rotation with hold 4 on a4; fixed unlimited hold on a0.
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 4; c++) begin
        e = 8'h01 << (k % 8);
        chk_bus("rr_rot", a4.gnt, a4.gnt_valid, a4.gnt_id, e);
        chk_bus("fix_hold", a0.gnt, a0.gnt_valid, a0.gnt_id, 8'h01);
        tick();
      end
    end

    a0.req = 8'hFE;
    a4.req = 8'h80;
    tick();
    chk_bus("fix_drop0", a0.gnt, a0.gnt_valid, a0.gnt_id, 8'h02);
    chk_bus("lone_take", a4.gnt, a4.gnt_valid, a4.gnt_id, 8'h80);
    a0.req = 8'h30;
    tick();
    chk_bus("fix_30", a0.gnt, a0.gnt_valid, a0.gnt_id, 8'h10);
    for (int c = 0; c < 11; c++) begin
      chk_bus("lone_hold", a4.gnt, a4.gnt_valid, a4.gnt_id, 8'h80);
      tick();
    end
    chk("lone_ptr", {29'd0, dut4.ptr_r}, 32'd0);

    rst    = 1'b1;
    a4.req = 8'h30;
    tick();
    chk_bus("rst_mid1", a4.gnt, a4.gnt_valid, a4.gnt_id, 8'h00);
    rst = 1'b0;
    tick();
    chk_bus("rr_30", a4.gnt, a4.gnt_valid, a4.gnt_id, 8'h10);
    a4.req = 8'h20;
    tick();
    chk_bus("rr_hand", a4.gnt, a4.gnt_valid, a4.gnt_id, 8'h20);
    a4.req = 8'h00;
    tick();
    chk_bus("rr_idle", a4.gnt, a4.gnt_valid, a4.gnt_id, 8'h00);

    // Mode switch while bit 5 owns the grant.
    a4.req = 8'h20;
    tick();
    chk_bus("sw_own5", a4.gnt, a4.gnt_valid, a4.gnt_id, 8'h20);
    chk("sw_ptr6", {29'd0, dut4.ptr_r}, 32'd6);
    a4.req  = 8'hFF;
    a4.mode = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_bus("sw_keep", a4.gnt, a4.gnt_valid, a4.gnt_id, 8'h20);
    end
    tick();
    chk_bus("sw_fixed", a4.gnt, a4.gnt_valid, a4.gnt_id, 8'h01);
    chk("sw_ptr_fixed", {29'd0, dut4.ptr_r}, 32'd6);

    rst = 1'b1;
    tick();
    chk_bus("rst_mid2", a4.gnt, a4.gnt_valid, a4.gnt_id, 8'h00);
    chk("rst_ptr", {29'd0, dut4.ptr_r}, 32'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
